// File: rtl/hx711_pkg.sv
// Shared types and constants for the HX711 load-cell ADC controller.
`timescale 1ns/1ps
package hx711_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SCK_HI,
        SCK_LO,
        DONE,
        PWRDN
    } state_t;

    localparam logic [1:0] GAIN_A128 = 2'b00;
    localparam logic [1:0] GAIN_B32  = 2'b01;
    localparam logic [1:0] GAIN_A64  = 2'b10;

    localparam logic [4:0] PULSES_A128 = 5'd25;
    localparam logic [4:0] PULSES_B32  = 5'd26;
    localparam logic [4:0] PULSES_A64  = 5'd27;

    localparam int         DATA_BITS   = 24;
    localparam logic [4:0] DATA_PULSES = 5'd24;

    // The extra pulses beyond 24 select the gain of the following conversion.
    function automatic logic [4:0] gain_to_pulses(input logic [1:0] gain);
        case (gain)
            GAIN_B32: return PULSES_B32;
            GAIN_A64: return PULSES_A64;
            default:  return PULSES_A128;
        endcase
    endfunction

endpackage

// File: rtl/hx711_half_timer.sv
// Loadable down-counter timing one pd_sck half-period; expire is high on its last cycle.
`timescale 1ns/1ps
module hx711_half_timer #(
    parameter int HALF_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic expire
);

    localparam int CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(HALF_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/hx711_ctrl.sv
// HX711 controller: waits for data-ready, clocks out 24 bits plus gain pulses, handles power-down.
`timescale 1ns/1ps
module hx711_ctrl
    import hx711_pkg::*;
#(
    parameter int HALF_CYCLES = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           gain_sel,
    input  logic                 pd_req,
    input  logic                 dout,
    output logic                 pd_sck,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 busy
);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [4:0]             count_q, count_d;
    logic [4:0]             pulse_q, pulse_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   pd_sck_q, pd_sck_d;
    logic                   timer_load;
    logic                   timer_expire;
    logic                   dout_s;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_d[gi] = dout;
        end else begin : g_rest
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    assign dout_s = sync_q[SYNC_STAGES-1];

    hx711_half_timer #(
        .HALF_CYCLES(HALF_CYCLES)
    ) u_half_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (timer_load),
        .expire (timer_expire)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        pulse_d      = pulse_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        timer_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pd_req) begin
                    state_d = PWRDN;
                end else if (start) begin
                    count_d = gain_to_pulses(gain_sel);
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (!dout_s) begin
                    pulse_d    = '0;
                    timer_load = 1'b1;
                    state_d    = SCK_HI;
                end
            end
            SCK_HI: begin
                if (timer_expire) begin
                    if (pulse_q < DATA_PULSES) begin
                        shift_d = {shift_q[DATA_BITS-2:0], dout_s};
                    end
                    timer_load = 1'b1;
                    state_d    = SCK_LO;
                end
            end
            SCK_LO: begin
                if (timer_expire) begin
                    pulse_d = pulse_q + 5'd1;
                    // data and data_valid are registered here so they are visible during DONE.
                    if (pulse_q + 5'd1 == count_q) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = SCK_HI;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            PWRDN: begin
                if (!pd_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pd_sck_d = (state_d == SCK_HI) || (state_d == PWRDN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sync_q       <= '1;
            count_q      <= '0;
            pulse_q      <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            pd_sck_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            count_q      <= count_d;
            pulse_q      <= pulse_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            pd_sck_q     <= pd_sck_d;
        end
    end

    assign pd_sck     = pd_sck_q;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q != IDLE) && (state_q != PWRDN);

endmodule

// File: doc/hx711_ctrl.md
HX711_CTRL -- requirements
Module: hx711_ctrl

Interface
REQ-001 Parameter HALF_CYCLES, default 64, meaning clk cycles per pd_sck half-period (1.28 us at 50 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, meaning number of flops in the dout synchronizer.
REQ-003 Port clk, input, 1, 50 MHz system clock; the only clock.
REQ-004 Port reset_n, input, 1, reset; synchronous, active-low.
REQ-005 Port start, input, 1, one-cycle conversion request.
REQ-006 Port gain_sel, input, 2, next-conversion gain: 00 = A/128 (25 pulses), 01 = B/32 (26 pulses), 10 = A/64 (27 pulses), 11 = treated as 00.
REQ-007 Port pd_req, input, 1, level request to power down the HX711.
REQ-008 Port dout, input, 1, asynchronous HX711 data/ready line; low means ready.
REQ-009 Port pd_sck, output, 1, HX711 serial clock.
REQ-010 Port data, output, 24, last conversion as two's complement, MSB first as received.
REQ-011 Port data_valid, output, 1, one-cycle pulse when data updates.
REQ-012 Port busy, output, 1, high in every state except IDLE and PWRDN.

Function
REQ-013 dout shall pass through a SYNC_STAGES-flop synchronizer; all decisions shall use the synchronized value dout_s.
REQ-014 FSM states: IDLE, WAIT_RDY, SCK_HI, SCK_LO, DONE, PWRDN.
REQ-015 IDLE: if pd_req=1, go to PWRDN; else if start=1, latch the pulse count from gain_sel and go to WAIT_RDY.
REQ-016 pd_req shall have priority over a simultaneous start.
REQ-017 start outside IDLE shall be ignored, with no queuing.
REQ-018 WAIT_RDY: hold pd_sck=0 until dout_s=0, then clear the pulse counter and go to SCK_HI; there is no timeout.
REQ-019 SCK_HI: drive pd_sck=1 for exactly HALF_CYCLES clk cycles, then go to SCK_LO.
REQ-020 Sampling: on the last cycle of SCK_HI, for pulse index 0..23, shift dout_s into the shift register LSB with the MSB shifted out first-in; pulses 24..26 shall not sample.
REQ-021 SCK_LO: drive pd_sck=0 for exactly HALF_CYCLES cycles, then increment the pulse counter.
REQ-022 At the end of SCK_LO, if the counter equals the latched count, go to DONE; else go to SCK_HI.
REQ-023 DONE (one cycle): copy the shift register to data, assert data_valid=1 for this cycle only, then go to IDLE.
REQ-024 Conversion length shall be exactly (count*2*HALF_CYCLES) cycles from the first SCK_HI cycle to DONE.
REQ-025 PWRDN: drive pd_sck=1 for as long as pd_req=1; when pd_req=0, drive pd_sck=0 and go to IDLE.
REQ-026 The next conversion after power-down shall use gain A/128, per HX711 behaviour; this is the caller's responsibility, and the block shall add no special case.
REQ-027 pd_req asserted mid-conversion shall be ignored until IDLE is reached.
REQ-028 data shall hold its value between conversions.
REQ-029 pd_sck shall be registered, with no combinational path from the FSM to the output.

Reset
REQ-030 reset_n=0 at a clk edge shall force state=IDLE, pd_sck=0, data=24'h000000, data_valid=0, busy=0, counters=0, and synchronizer flops=1.
REQ-031 Reset mid-conversion shall abort it; the partial shift register shall not reach data and no data_valid shall be produced.

Structure
REQ-032 Package hx711_pkg shall hold the state enum, the gain_sel encodings, and the pulse-count constants 25/26/27.
REQ-033 One sub-module, hx711_half_timer, shall be a HALF_CYCLES down-counter with load and an expire pulse; it shall be instantiated once and reused for both SCK phases.

Verification
REQ-034 dout model holds low, start with gain_sel=00, model shifts 24'h800001 -> exactly 25 pd_sck pulses, each 64 cycles high and 64 cycles low; data=24'h800001; one data_valid pulse.
REQ-035 gain_sel=01 then gain_sel=10 -> 26 and then 27 pulses; data matches the model's 24'h123456 and 24'hFFFFFF respectively.
REQ-036 start with dout=1 for 1000 cycles, then dout=0 -> pd_sck stays 0 and busy=1 throughout the wait; first rising edge of pd_sck occurs 2-3 cycles after dout falls.
REQ-037 reset_n=0 for 1 cycle during pulse 10 -> pd_sck=0 and busy=0 on the next cycle; data unchanged at 0; no data_valid.
REQ-038 pd_req=1 and start=1 in the same IDLE cycle -> PWRDN entered, pd_sck=1 held for a 4000-cycle pd_req; after release, pd_sck=0 and IDLE reached; start pulses during pd_req are ignored.
REQ-039 start pulsed repeatedly during a conversion -> exactly one conversion and one data_valid pulse.
